// File: rtl/pixel_plot_sink.sv
// Pixel plot sink: queues plot requests in a small FIFO and streams them to a
// framebuffer write port, with a full-screen fill that takes priority over queued pixels.
module pixel_plot_sink #(
    parameter int unsigned SCR_W      = 320,
    parameter int unsigned SCR_H      = 240,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  in_x,
    input  logic [7:0]  in_y,
    input  logic [2:0]  in_c,
    input  logic        clear_req,
    input  logic [2:0]  clear_color,
    output logic [16:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    output logic        busy,
    output logic        clear_done,
    output logic [7:0]  drop_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [16:0]   LAST_ADDR = 17'(SCR_W * SCR_H - 1);

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    pix_t          fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [2:0]    color_q, color_d;
    logic [16:0]   clr_addr_q, clr_addr_d;
    logic [16:0]   mem_addr_q, mem_addr_d;
    logic [2:0]    mem_data_q, mem_data_d;
    logic          mem_we_q, mem_we_d;
    logic          done_q, done_d;
    logic [7:0]    drop_q, drop_d;

    logic  push, pop, full, empty, in_range;
    pix_t  head;
    logic [16:0] pix_addr;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign in_ready = resetn && !full;
    assign busy     = resetn && ((state_q != IDLE) || !empty);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == WRITE) && !empty;

    assign head     = fifo_q[rd_ptr_q];
    assign in_range = ({23'd0, head.x} < SCR_W) && ({24'd0, head.y} < SCR_H);
    assign pix_addr = 17'(head.y) * 17'(SCR_W) + 17'(head.x);

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;
    assign clear_done = done_q;
    assign drop_count = drop_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        color_d    = color_q;
        clr_addr_d = clr_addr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        done_d     = 1'b0;
        drop_d     = drop_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    color_d    = clear_color;
                    clr_addr_d = '0;
                end else if (!empty) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (pop) begin
                    if (in_range) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = pix_addr;
                        mem_data_d = head.c;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
                // A pop always finishes in this cycle, so a clear request
                // seen here is carried straight into CLEAR on the same edge.
                if (clear_req) begin
                    state_d    = CLEAR;
                    color_d    = clear_color;
                    clr_addr_d = '0;
                end else if (count_d == '0) begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                mem_we_d   = 1'b1;
                mem_addr_d = clr_addr_q;
                mem_data_d = color_q;
                if (clr_addr_q == LAST_ADDR) begin
                    done_d     = 1'b1;
                    clr_addr_d = '0;
                    state_d    = (count_d != '0) ? WRITE : IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 17'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            color_q    <= '0;
            clr_addr_q <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            color_q    <= color_d;
            clr_addr_q <= clr_addr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{x: in_x, y: in_y, c: in_c};
    end

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Directed bench for pixel_plot_sink: single pixels, FIFO backpressure,
// drops and saturation, full-screen fill, clear during WRITE, reset mid-fill.
module tb_pixel_plot_sink;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  in_x = '0;
    logic [7:0]  in_y = '0;
    logic [2:0]  in_c = '0;
    logic        clear_req = 1'b0;
    logic [2:0]  clear_color = '0;
    logic [16:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        busy;
    logic        clear_done;
    logic [7:0]  drop_count;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] px_x [5] = '{9'd1, 9'd4, 9'd7, 9'd10, 9'd13};
    logic [7:0] px_y [5] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    logic [2:0] px_c [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    int         px_a [5] = '{641, 964, 1287, 1610, 1933};

    pixel_plot_sink dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_c(in_c),
        .clear_req(clear_req), .clear_color(clear_color),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .busy(busy), .clear_done(clear_done), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
        in_valid = v;
        in_x = x;
        in_y = y;
        in_c = c;
    endtask

    initial begin
        int bad;

        // reset state
        tick;
        tick;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_done", 32'(clear_done), 0);
        chk("rst_drop", 32'(drop_count), 0);
        resetn = 1'b1;
        #1;
        chk("ready_after_rst", 32'(in_ready), 1);

        // single pixel, 2-edge latency
        drive(1'b1, 9'd10, 8'd5, 3'd7);
        tick;
        drive(1'b0, 9'd0, 8'd0, 3'd0);
        chk("px_we_e0", 32'(mem_we), 0);
        tick;
        chk("px_we_e1", 32'(mem_we), 0);
        chk("px_busy_e1", 32'(busy), 1);
        tick;
        chk("px_we_e2", 32'(mem_we), 1);
        chk("px_addr_e2", 32'(mem_addr), 1610);
        chk("px_data_e2", 32'(mem_data), 7);
        chk("px_busy_e2", 32'(busy), 0);
        tick;
        chk("px_we_e3", 32'(mem_we), 0);
        chk("px_addr_hold", 32'(mem_addr), 1610);

        // last in-range pixel
        drive(1'b1, 9'd319, 8'd239, 3'd4);
        tick;
        drive(1'b0, 9'd0, 8'd0, 3'd0);
        tick;
        tick;
        chk("max_we", 32'(mem_we), 1);
        chk("max_addr", 32'(mem_addr), 76799);
        chk("max_data", 32'(mem_data), 4);
        tick;

        // first out-of-range column and row
        drive(1'b1, 9'd320, 8'd0, 3'd1);
        tick;
        drive(1'b1, 9'd0, 8'd240, 3'd1);
        tick;
        drive(1'b0, 9'd0, 8'd0, 3'd0);
        tick;
        chk("oor_we_a", 32'(mem_we), 0);
        tick;
        chk("oor_we_b", 32'(mem_we), 0);
        chk("oor_addr_hold", 32'(mem_addr), 76799);
        chk("oor_drop2", 32'(drop_count), 2);
        chk("oor_idle", 32'(busy), 0);

        // full fill, pixel queued in the same cycle, FIFO fills during the fill
        clear_req = 1'b1;
        clear_color = 3'd1;
        drive(1'b1, px_x[0], px_y[0], px_c[0]);
        tick;
        clear_req = 1'b0;
        chk("fill_busy", 32'(busy), 1);
        bad = 0;
        for (int k = 0; k < 76800; k++) begin
            if (k <= 3) drive(1'b1, px_x[k+1], px_y[k+1], px_c[k+1]);
            if (k == 100) begin
                clear_req = 1'b1;
                clear_color = 3'd6;
            end
            if (k == 101) clear_req = 1'b0;
            tick;
            if (mem_we !== 1'b1 || mem_addr !== 17'(k) || mem_data !== 3'd1) bad++;
            if (clear_done !== (k == 76799)) bad++;
            if (k == 2) chk("fifo_full_ready", 32'(in_ready), 0);
        end
        chk("fill_sequence", 32'(bad), 0);
        chk("fill_done", 32'(clear_done), 1);
        chk("fill_last_addr", 32'(mem_addr), 76799);
        for (int j = 0; j < 5; j++) begin
            tick;
            chk("post_fill_we", 32'(mem_we), 1);
            chk("post_fill_addr", 32'(mem_addr), 32'(px_a[j]));
            chk("post_fill_data", 32'(mem_data), 32'(px_c[j]));
            if (j == 0) chk("done_one_cycle", 32'(clear_done), 0);
            if (j == 1) drive(1'b0, 9'd0, 8'd0, 3'd0);
        end
        chk("post_fill_idle", 32'(busy), 0);
        tick;
        chk("post_fill_we_off", 32'(mem_we), 0);

        // drop counter saturation
        drive(1'b1, 9'd400, 8'd250, 3'd2);
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            tick;
            if (mem_we !== 1'b0) bad++;
        end
        drive(1'b0, 9'd0, 8'd0, 3'd0);
        for (int k = 0; k < 10 && busy; k++) tick;
        chk("drain_timeout", 32'(busy), 0);
        chk("drop_no_writes", 32'(bad), 0);
        chk("drop_saturate", 32'(drop_count), 255);

        // clear arriving in WRITE, then reset at fill address 1000
        drive(1'b1, 9'd2, 8'd0, 3'd3);
        tick;
        drive(1'b1, 9'd3, 8'd0, 3'd3);
        tick;
        drive(1'b1, 9'd4, 8'd0, 3'd3);
        clear_req = 1'b1;
        clear_color = 3'd5;
        tick;
        drive(1'b0, 9'd0, 8'd0, 3'd0);
        clear_req = 1'b0;
        chk("wclr_pop_we", 32'(mem_we), 1);
        chk("wclr_pop_addr", 32'(mem_addr), 2);
        chk("wclr_pop_data", 32'(mem_data), 3);
        tick;
        chk("wclr_fill0_addr", 32'(mem_addr), 0);
        chk("wclr_fill0_data", 32'(mem_data), 5);
        bad = 0;
        for (int k = 1; k <= 1000; k++) begin
            tick;
            if (mem_we !== 1'b1 || mem_addr !== 17'(k) || mem_data !== 3'd5) bad++;
        end
        chk("wclr_fill_seq", 32'(bad), 0);
        chk("wclr_at_1000", 32'(mem_addr), 1000);
        resetn = 1'b0;
        tick;
        chk("abort_we", 32'(mem_we), 0);
        chk("abort_addr", 32'(mem_addr), 0);
        chk("abort_data", 32'(mem_data), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(in_ready), 0);
        chk("abort_done", 32'(clear_done), 0);
        chk("abort_drop", 32'(drop_count), 0);
        tick;
        resetn = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (mem_we !== 1'b0 || clear_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("abort_quiet", 32'(bad), 0);
        chk("abort_ready_back", 32'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_plot_sink.md
PIXEL_PLOT_SINK -- requirements
Module: pixel_plot_sink

Interface
REQ-001 Parameter SCR_W, default 320, visible width in pixels.
REQ-002 Parameter SCR_H, default 240, visible height in pixels.
REQ-003 Parameter FIFO_DEPTH, default 4, number of pixel-request buffer entries; power of 2.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  plot request present on in_x/in_y/in_c.
REQ-007 in_ready  output  1  sink can accept a request this cycle.
REQ-008 in_x  input  9  pixel column.
REQ-009 in_y  input  8  pixel row.
REQ-010 in_c  input  3  pixel colour, RGB one bit each.
REQ-011 clear_req  input  1  single-cycle pulse requesting a full-screen fill.
REQ-012 clear_color  input  3  fill colour, sampled when clear_req is accepted.
REQ-013 mem_addr  output  17  framebuffer write address, registered.
REQ-014 mem_data  output  3  framebuffer write data, registered.
REQ-015 mem_we  output  1  framebuffer write strobe, registered, one write per cycle.
REQ-016 busy  output  1  high while state is not IDLE or the FIFO is non-empty.
REQ-017 clear_done  output  1  one-cycle pulse when a fill completes.
REQ-018 drop_count  output  8  count of out-of-range requests discarded, saturating.

Function
REQ-019 A handshake occurs on an edge where in_valid and in_ready are both 1; {in_x,in_y,in_c} is pushed to the FIFO tail.
REQ-020 in_ready shall be !fifo_full; it is independent of in_valid and of FSM state, so requests may be queued during a fill.
REQ-021 When the FIFO is full, in_ready is 0 even if a pop occurs in the same cycle.
REQ-022 A simultaneous push and pop leaves the FIFO count unchanged, and ordering is strictly FIFO.
REQ-023 FSM states: IDLE, WRITE, CLEAR.
REQ-024 IDLE: clear_req goes to CLEAR; otherwise a non-empty FIFO goes to WRITE; otherwise stay in IDLE. clear_req has priority over pending pixels.
REQ-025 WRITE: each edge pops the FIFO head and registers mem outputs. If the FIFO is empty after the pop and there is no concurrent push, go to IDLE.
REQ-026 A clear_req arriving in WRITE is latched as pending. The current pop completes, then the FSM goes to CLEAR; remaining FIFO entries wait.
REQ-027 In-range pop (in_x < SCR_W and in_y < SCR_H): mem_addr = in_y*SCR_W + in_x, computed at 17-bit width without truncation; mem_data = in_c; mem_we = 1.
REQ-028 Out-of-range pop: mem_we = 0 and drop_count increments, saturating at 255.
REQ-029 Latency: a request accepted at edge E into an empty FIFO with the FSM in IDLE appears on the mem port after edge E+2.
REQ-030 Back-to-back pixels stream at one mem write per cycle while in WRITE.
REQ-031 CLEAR: clear_color is latched on entry. Addresses 0 to SCR_W*SCR_H-1 are written in ascending order, one per cycle, with mem_we = 1.
REQ-032 After the last address (76799 with defaults), clear_done pulses for 1 cycle. The FSM then goes to WRITE if the FIFO is non-empty, else to IDLE.
REQ-033 A clear_req received during CLEAR is ignored.
REQ-034 In any cycle with no write, mem_we = 0 and mem_addr/mem_data hold their previous values.

Reset
REQ-035 While resetn = 0 at an edge: state is IDLE, the FIFO is emptied, the pending clear is cleared, mem_addr = 0, mem_data = 0, mem_we = 0, clear_done = 0, drop_count = 0.
REQ-036 While resetn = 0, in_ready = 0 and busy = 0.
REQ-037 Reset mid-fill or mid-stream aborts immediately; no further writes occur, and queued pixels are lost.

Verification
REQ-038 Single pixel (x=10, y=5, c=3'b111) into an idle sink -> after 2 edges mem_we = 1, mem_addr = 1610, mem_data = 7 for exactly 1 cycle.
REQ-039 Push 5 requests back-to-back with FIFO_DEPTH = 4 and no pops possible in the first cycles -> in_ready drops when 4 entries are held. All 5 are written in push order at 1 per cycle.
REQ-040 Out-of-range request x=320, y=0, then x=0, y=240 -> no mem_we, drop_count = 2. 300 out-of-range requests -> drop_count = 255.
REQ-041 clear_req with clear_color = 3'b001 -> 76800 consecutive writes covering addresses 0 to 76799 with data 1, then a clear_done pulse. Pixels pushed during the fill are written after the fill.
REQ-042 clear_req in the same cycle a pixel is queued from IDLE -> the fill runs first, then the pixel is written.
REQ-043 resetn = 0 at fill address 1000 -> mem_we = 0 on the next edge, mem_addr = 0, busy = 0, and no clear_done pulse.
